// File: rtl/muldiv_if.sv
// ---------------------------------------------------------------------------
// muldiv_if : operand/result handshake bundle for muldiv_unit   (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

interface muldiv_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      func3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, func3, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, func3, op_a, op_b, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit : iterative RV M-extension multiply/divide unit   (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  wire        clk,
  input  wire        rst_n,
  input  wire        flush,
  muldiv_if.slave    bus
);
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt;
  logic              is_div;
  logic              sel_alt;
  logic              neg_res;
  logic              neg_rem;
  logic [XLEN-1:0]   opnd;
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   result_q;

  logic              accept;
  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_abs, b_abs;
  logic              div0, ovf, special;
  logic [XLEN-1:0]   special_res;
  logic              last_iter;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     diff;
  logic [2*XLEN-1:0] acc_nxt;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;
  logic [XLEN-1:0]   final_res;

  assign accept = bus.in_valid & (state_q == IDLE) & ~flush;

  // Only MULHSU mixes signedness; the *U ops are unsigned on both sides.
  assign a_signed = bus.func3[2] ? ~bus.func3[0] : ~(bus.func3[1] & bus.func3[0]);
  assign b_signed = bus.func3[2] ? ~bus.func3[0] : ~bus.func3[1];
  assign a_neg    = a_signed & bus.op_a[XLEN-1];
  assign b_neg    = b_signed & bus.op_b[XLEN-1];
  assign a_abs    = a_neg ? (~bus.op_a + 1'b1) : bus.op_a;
  assign b_abs    = b_neg ? (~bus.op_b + 1'b1) : bus.op_b;

  assign div0    = bus.func3[2] & (bus.op_b == '0);
  assign ovf     = bus.func3[2] & ~bus.func3[0] & (bus.op_a == {1'b1, {(XLEN-1){1'b0}}})
                 & (&bus.op_b);
  assign special = div0 | ovf;
  assign special_res = div0 ? (bus.func3[1] ? bus.op_a : {XLEN{1'b1}})
                            : (bus.func3[1] ? '0 : bus.op_a);

  assign last_iter = (cnt == CW'(XLEN-1));

  // Multiply keeps the multiplier in acc's low half; divide keeps the dividend there.
  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
  assign rem_sh  = acc[2*XLEN-1:XLEN-1];
  assign diff    = rem_sh - {1'b0, opnd};

  always_comb begin
    acc_nxt = acc;
    if (is_div) begin
      if (diff[XLEN]) acc_nxt = {acc[2*XLEN-2:0], 1'b0};
      else            acc_nxt = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      acc_nxt = {mul_sum, acc[XLEN-1:1]};
    end
  end

  assign prod = neg_res ? (~acc_nxt + 1'b1) : acc_nxt;
  assign quo  = neg_res ? (~acc_nxt[XLEN-1:0] + 1'b1) : acc_nxt[XLEN-1:0];
  assign rem  = neg_rem ? (~acc_nxt[2*XLEN-1:XLEN] + 1'b1) : acc_nxt[2*XLEN-1:XLEN];
  assign final_res = is_div ? (sel_alt ? rem : quo)
                            : (sel_alt ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = special ? DONE : CALC;
      CALC:    if (last_iter) state_d = DONE;
      DONE:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (flush) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      is_div   <= 1'b0;
      sel_alt  <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
      result_q <= '0;
    end else if (!flush) begin
      if (state_q == IDLE && accept) begin
        cnt     <= '0;
        is_div  <= bus.func3[2];
        sel_alt <= bus.func3[2] ? bus.func3[1] : (bus.func3[1:0] != 2'b00);
        neg_res <= a_neg ^ b_neg;
        neg_rem <= a_neg;
        opnd    <= bus.func3[2] ? b_abs : a_abs;
        acc     <= {{XLEN{1'b0}}, (bus.func3[2] ? a_abs : b_abs)};
        if (special) result_q <= special_res;
      end else if (state_q == CALC) begin
        acc <= acc_nxt;
        cnt <= cnt + 1'b1;
        if (last_iter) result_q <= final_res;
      end
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.result    = result_q;
endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Parametrised iterative multiply/divide execution unit implementing the RV M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU). It sits beside the single-cycle ALU in EX. The decoder routes R-type ops with func7 = 0000001 here, using func3 directly as the op select. Valid/ready handshakes are used on both sides. A flush input lets the pipeline abort an in-flight op.

Parameters:
XLEN, 32, operand/result width in bits (>= 8, even)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous, active-low reset
flush  in  1  synchronous abort of any in-flight op
in_valid  in  1  op_a/op_b/func3 valid
in_ready  out  1  unit can accept an op (combinational: state==IDLE)
func3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  in  XLEN  rs1 value (multiplicand/dividend)
op_b  in  XLEN  rs2 value (multiplier/divisor)
out_valid  out  1  result valid, held until taken
out_ready  in  1  consumer takes result
result  out  XLEN  selected result
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, out_valid=0, result=0, iteration counter=0, operand/accumulator registers=0.
  - in_ready=1 once rst_n is high.
- States:
  - IDLE -> CALC on accept (in_valid & in_ready & ~flush), non-special op.
  - IDLE -> DONE on accept of a special-case divide.
  - CALC -> DONE after the XLEN-th iteration.
  - DONE -> IDLE on out_ready.
  - flush=1 -> IDLE from any state on the next edge; out_valid cleared; flush beats in_valid in the same cycle (no accept).
- Accept edge:
  - Latch func3, sign flags, and absolute values.
  - Signedness: MUL/MULH/DIV/REM treat both operands as signed. MULHSU: op_a signed, op_b unsigned. MULHU/DIVU/REMU: both unsigned. MUL low word is identical for signed and unsigned operands.
  - Clear counter.
- Multiply:
  - Shift-add, one multiplier bit per CALC cycle, 2*XLEN-bit accumulator.
  - Final product negated (two's complement, 2*XLEN bits) iff exactly one signed operand was negative.
  - MUL returns product[XLEN-1:0]; MULH/MULHSU/MULHU return product[2XLEN-1:XLEN].
- Divide:
  - Restoring, one quotient bit per CALC cycle on magnitudes.
  - Signed quotient negated iff operand signs differ; signed remainder takes the dividend's sign.
- Special cases, resolved at the accept edge (DONE with result registered one cycle after accept, no CALC):
  - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> op_a.
  - Signed overflow, op_a = 1 followed by XLEN-1 zeros and op_b = all ones, DIV/REM only: DIV -> op_a, REM -> 0.
- Latency:
  - Normal ops: out_valid rises exactly XLEN cycles after the accept edge (sign fix-up is applied on the last CALC edge).
  - Special cases: 1 cycle after the accept edge.
- DONE:
  - out_valid=1; result and out_valid are held stable while out_ready=0.
  - in_ready=0, and in_valid is ignored.
  - Handshake completes on the edge with out_valid & out_ready. The next cycle is IDLE with out_valid=0 and result holding its last value.
  - No accept in the same cycle as the result handoff.
- Input side: func3/op_a/op_b changing after accept has no effect on the in-flight op.

Test Plan:
1. XLEN=32, MUL op_a=7, op_b=0xFFFFFFFD -> result 0xFFFFFFEB; out_valid exactly 32 cycles after accept; busy high throughout.
2. High-word multiplies, one at a time:
   - MULH 0x80000000*0x80000000 -> 0x40000000.
   - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
   - MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF.
3. Signed and unsigned divide:
   - DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD.
   - REM same operands -> 0xFFFFFFFF.
   - DIVU 100/7 -> 14; REMU 100/7 -> 2.
4. Special cases, each with out_valid 1 cycle after accept:
   - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
   - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
5. Backpressure: hold out_ready=0 for 5 cycles in DONE while pulsing in_valid -> result stable, in_ready=0, no accept. Raise out_ready -> IDLE next cycle, in_ready=1, then a new op is accepted.
6. Abort and reset:
   - flush on the 10th CALC cycle -> IDLE next edge, out_valid never asserted; a following op returns the correct result.
   - rst_n pulsed low mid-CALC -> outputs immediately at reset values.
